// File: rtl/j0_bus_pkg.sv
// Shared types and defaults for the j0 coprocessor memory bus.
//   arb_state_e : arbiter phase (idle, host access, guard stall, j0-only window)
//   host_req_t  : host request payload at default widths
package j0_bus_pkg;

    localparam int unsigned J0_AW = 16;
    localparam int unsigned J0_DW = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_GUARD  = 2'd2,
        ST_SLOT   = 2'd3
    } arb_state_e;

    typedef struct packed {
        logic             wr;
        logic [J0_AW-1:0] addr;
        logic [J0_DW-1:0] wdata;
    } host_req_t;

endpackage

// File: rtl/j0_mem_arbiter.sv
// Single-port RAM arbiter between the host bus and the j0 coprocessor.
// The host wins every access; j0 is paused through the access and GUARD
// cycles, then given J0_SLOTS unpaused cycles before the host may go again.
//   sys_clk_i, sys_rst_i          : clock, synchronous active-high reset
//   host_valid/ready/wr/addr/wdata: host request handshake
//   host_rvalid/host_rdata        : completion pulse and held read data
//   j0_mem_rd/wr/addr/dout/din    : j0 memory port
//   j0_pause                      : stall to j0
//   ram_addr/we/wdata/rdata       : RAM port (1-cycle read latency)
module j0_mem_arbiter
    import j0_bus_pkg::*;
#(
    parameter int unsigned AW       = J0_AW,
    parameter int unsigned DW       = J0_DW,
    parameter int unsigned GUARD    = 1,
    parameter int unsigned J0_SLOTS = 2
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,

    input  logic          host_valid,
    output logic          host_ready,
    input  logic          host_wr,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_rvalid,
    output logic [DW-1:0] host_rdata,

    input  logic          j0_mem_rd,
    input  logic          j0_mem_wr,
    input  logic [AW-1:0] j0_mem_addr,
    input  logic [DW-1:0] j0_mem_dout,
    output logic [DW-1:0] j0_mem_din,
    output logic          j0_pause,

    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam int unsigned CNT_MAX = (GUARD > J0_SLOTS) ? GUARD : J0_SLOTS;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    arb_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_q, wr_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          accept_c;

    // j0 read strobe carries no arbitration meaning; the RAM is always enabled
    logic unused_j0_mem_rd;
    assign unused_j0_mem_rd = j0_mem_rd;

    assign host_rvalid = rvalid_q;
    assign host_rdata  = rdata_q;
    assign j0_mem_din  = ram_rdata;

    // State, phase counter and host completion registers
    always_ff @(posedge sys_clk_i) begin
        if (sys_rst_i) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            wr_q     <= 1'b0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            wr_q     <= wr_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    // Next state, handshake, pause and RAM port mux
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;

        host_ready = (state_q == ST_IDLE) && !sys_rst_i;
        accept_c   = host_valid && host_ready;
        j0_pause   = !sys_rst_i &&
                     ((host_valid && (state_q == ST_IDLE)) ||
                      (state_q == ST_ACCESS) || (state_q == ST_GUARD));

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    state_d = ST_ACCESS;
                    wr_d    = host_wr;
                end
            end
            ST_ACCESS: begin
                // RAM data for the accepted address is on ram_rdata now
                rvalid_d = 1'b1;
                if (!wr_q) begin
                    rdata_d = ram_rdata;
                end
                state_d = ST_GUARD;
                cnt_d   = CW'(GUARD);
            end
            ST_GUARD: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_SLOT;
                    cnt_d   = CW'(J0_SLOTS);
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_SLOT: begin
                if (cnt_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Host owns the port only in its accept cycle; a paused j0 write is dropped
        if (accept_c) begin
            ram_addr  = host_addr;
            ram_we    = host_wr;
            ram_wdata = host_wdata;
        end else begin
            ram_addr  = j0_mem_addr;
            ram_we    = j0_mem_wr && !j0_pause;
            ram_wdata = j0_mem_dout;
        end
    end

endmodule

// File: tb/tb_j0_mem_arbiter.sv
// Self-checking bench for j0_mem_arbiter: default build with a RAM model and
// scoreboard, plus a GUARD=3 / J0_SLOTS=4 build for timing of the period.
module tb_j0_mem_arbiter;
    import j0_bus_pkg::*;

    localparam int unsigned G0 = 1;
    localparam int unsigned S0 = 2;
    localparam int unsigned G1 = 3;
    localparam int unsigned S1 = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        host_valid, host_ready, host_wr, host_rvalid;
    logic [15:0] host_addr, host_wdata, host_rdata;
    logic        j0_mem_rd, j0_mem_wr, j0_pause;
    logic [15:0] j0_mem_addr, j0_mem_dout, j0_mem_din;
    logic [15:0] ram_addr, ram_wdata, ram_rdata;
    logic        ram_we;

    logic        host_valid1, host_ready1, host_rvalid1, j0_pause1, ram_we1;
    logic [15:0] host_rdata1, j0_mem_din1, ram_addr1, ram_wdata1;
    logic [15:0] zero16 = 16'h0;
    logic        zero1 = 1'b0;

    j0_mem_arbiter #(.AW(16), .DW(16), .GUARD(G0), .J0_SLOTS(S0)) dut (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .host_valid(host_valid), .host_ready(host_ready), .host_wr(host_wr),
        .host_addr(host_addr), .host_wdata(host_wdata),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .j0_mem_rd(j0_mem_rd), .j0_mem_wr(j0_mem_wr), .j0_mem_addr(j0_mem_addr),
        .j0_mem_dout(j0_mem_dout), .j0_mem_din(j0_mem_din), .j0_pause(j0_pause),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    j0_mem_arbiter #(.AW(16), .DW(16), .GUARD(G1), .J0_SLOTS(S1)) dut1 (
        .sys_clk_i(clk), .sys_rst_i(rst),
        .host_valid(host_valid1), .host_ready(host_ready1), .host_wr(zero1),
        .host_addr(zero16), .host_wdata(zero16),
        .host_rvalid(host_rvalid1), .host_rdata(host_rdata1),
        .j0_mem_rd(zero1), .j0_mem_wr(zero1), .j0_mem_addr(zero16),
        .j0_mem_dout(zero16), .j0_mem_din(j0_mem_din1), .j0_pause(j0_pause1),
        .ram_addr(ram_addr1), .ram_we(ram_we1), .ram_wdata(ram_wdata1), .ram_rdata(zero16)
    );

    // RAM model with a preload port used during reset
    logic [15:0] mem [0:65535];
    logic        pl_we = 1'b0;
    logic [15:0] pl_addr = 16'h0, pl_data = 16'h0;
    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] sb [$];
    logic [15:0] shadow [logic [15:0]];
    logic [15:0] last_rd = 16'h0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        return shadow.exists(a) ? shadow[a] : 16'h0;
    endfunction

    // Scoreboard: every completion pulse pops one expected host_rdata
    always @(negedge clk) begin
        if (host_rvalid) begin
            if (sb.size() == 0) check_eq("rvalid_unexpected", 32'd1, 32'd0);
            else check_eq("sb_rdata", 32'(host_rdata), 32'(sb.pop_front()));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_we = 1'b1; pl_addr = a; pl_data = d;
        shadow[a] = d;
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk); #1;
        while (!host_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!host_ready) check_eq("ready_timeout", 32'd0, 32'd1);
    endtask

    task automatic host_op(input host_req_t req);
        int n = 0;
        @(negedge clk);
        host_valid = 1'b1; host_wr = req.wr; host_addr = req.addr; host_wdata = req.wdata;
        #1;
        while (!host_ready && n < 50) begin
            @(negedge clk); #1; n++;
        end
        if (!host_ready) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
        end else if (req.wr) begin
            sb.push_back(last_rd);
            shadow[req.addr] = req.wdata;
        end else begin
            last_rd = model_rd(req.addr);
            sb.push_back(last_rd);
        end
        @(negedge clk);
        host_valid = 1'b0;
    endtask

    initial begin
        int accepts, loads, zero_run, last_acc, prun, n_acc;
        logic prev_pause, j0_next, acc_now;

        rst = 1'b1;
        host_valid = 1'b1; host_wr = 1'b0; host_addr = 16'h0; host_wdata = 16'h0;
        j0_mem_rd = 1'b0; j0_mem_wr = 1'b0; j0_mem_addr = 16'h0; j0_mem_dout = 16'h0;
        host_valid1 = 1'b0;

        // Reset state, with a host request pending to show pause is forced low
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_ready", 32'(host_ready), 32'd0);
        check_eq("rst_pause", 32'(j0_pause), 32'd0);
        check_eq("rst_rvalid", 32'(host_rvalid), 32'd0);
        check_eq("rst_rdata", 32'(host_rdata), 32'd0);
        host_valid = 1'b0;
        preload(16'h0010, 16'hBEEF);
        for (int k = 0; k < 16; k++) preload(16'h0100 + 16'(k), 16'hC000 + 16'(k));
        @(negedge clk);
        pl_we = 1'b0;
        rst = 1'b0;
        #1;
        check_eq("post_rst_ready", 32'(host_ready), 32'd1);

        // Single host read: cycle-accurate handshake
        wait_ready();
        @(negedge clk);
        host_valid = 1'b1; host_wr = 1'b0; host_addr = 16'h0010;
        #1;
        for (int c = 0; c <= 6; c++) begin
            if (c > 0) begin
                @(negedge clk); host_valid = 1'b0; #1;
            end
            if (c == 0) begin
                last_rd = model_rd(16'h0010);
                sb.push_back(last_rd);
            end
            check_eq($sformatf("t1_ready_c%0d", c), 32'(host_ready), 32'(c == 0 || c >= int'(2 + G0 + S0)));
            check_eq($sformatf("t1_pause_c%0d", c), 32'(j0_pause), 32'(c <= int'(1 + G0)));
            check_eq($sformatf("t1_rvalid_c%0d", c), 32'(host_rvalid), 32'(c == 2));
        end
        check_eq("t1_rdata_hold", 32'(host_rdata), 32'h0000BEEF);

        // Write then read back; the write completion keeps previous rdata
        host_op('{wr: 1'b1, addr: 16'h0020, wdata: 16'h1234});
        host_op('{wr: 1'b0, addr: 16'h0020, wdata: 16'h0000});

        // Collision: host write and j0 write to the same address
        wait_ready();
        @(negedge clk);
        host_valid = 1'b1; host_wr = 1'b1; host_addr = 16'h0030; host_wdata = 16'hAAAA;
        j0_mem_wr = 1'b1; j0_mem_addr = 16'h0030; j0_mem_dout = 16'h5555;
        #1;
        check_eq("t3_acc_ready", 32'(host_ready), 32'd1);
        check_eq("t3_acc_we", 32'(ram_we), 32'd1);
        check_eq("t3_acc_wdata", 32'(ram_wdata), 32'h0000AAAA);
        check_eq("t3_acc_addr", 32'(ram_addr), 32'h00000030);
        check_eq("t3_acc_pause", 32'(j0_pause), 32'd1);
        sb.push_back(last_rd);
        for (int c = 1; c <= 2; c++) begin
            @(negedge clk); host_valid = 1'b0; #1;
            check_eq($sformatf("t3_we_supp_c%0d", c), 32'(ram_we), 32'd0);
            if (c == 1) check_eq("t3_host_landed", 32'(mem[16'h0030]), 32'h0000AAAA);
        end
        @(negedge clk); #1;
        check_eq("t3_slot_pause", 32'(j0_pause), 32'd0);
        check_eq("t3_slot_we", 32'(ram_we), 32'd1);
        check_eq("t3_slot_wdata", 32'(ram_wdata), 32'h00005555);
        @(negedge clk);
        j0_mem_wr = 1'b0;
        shadow[16'h0030] = 16'h5555;
        host_op('{wr: 1'b0, addr: 16'h0030, wdata: 16'h0000});

        // Continuous host stream against a j0 load loop
        wait_ready();
        j0_mem_rd = 1'b1;
        j0_mem_addr = 16'h0100;
        accepts = 0; loads = 0; zero_run = 0; prev_pause = 1'b0;
        @(negedge clk);
        host_valid = 1'b1; host_wr = 1'b0; host_addr = 16'h0100;
        #1;
        for (int c = 0; c < 10 * int'(2 + G0 + S0); c++) begin
            j0_next = 1'b0; acc_now = 1'b0;
            if (!j0_pause && prev_pause) begin
                check_eq($sformatf("t4_load%0d", loads), 32'(j0_mem_din), 32'(model_rd(j0_mem_addr)));
                loads++;
                j0_next = 1'b1;
            end
            if (!j0_pause) zero_run++;
            if (host_ready && host_valid) begin
                if (accepts > 0) check_eq($sformatf("t4_gap%0d", accepts), 32'(zero_run), 32'(S0));
                zero_run = 0;
                last_rd = model_rd(host_addr);
                sb.push_back(last_rd);
                accepts++;
                acc_now = 1'b1;
            end
            prev_pause = j0_pause;
            @(negedge clk);
            if (acc_now) host_addr = 16'h0100 + 16'(accepts);
            if (j0_next) j0_mem_addr = j0_mem_addr + 16'd1;
            if (accepts >= 10) host_valid = 1'b0;
            #1;
        end
        check_eq("t4_accepts", 32'(accepts), 32'd10);
        check_eq("t4_loads", 32'(loads), 32'd10);
        j0_mem_rd = 1'b0;

        // Reset during ACCESS cancels the completion
        wait_ready();
        @(negedge clk);
        host_valid = 1'b1; host_wr = 1'b0; host_addr = 16'h0010;
        #1;
        check_eq("t5_accept", 32'(host_ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        j0_mem_wr = 1'b1; j0_mem_addr = 16'h0200; j0_mem_dout = 16'h7777;
        #1;
        check_eq("t5_rst_ready", 32'(host_ready), 32'd0);
        check_eq("t5_rst_pause", 32'(j0_pause), 32'd0);
        check_eq("t5_rst_we", 32'(ram_we), 32'd1);
        @(negedge clk);
        rst = 1'b0; host_valid = 1'b0; j0_mem_wr = 1'b0;
        #1;
        check_eq("t5_rvalid", 32'(host_rvalid), 32'd0);
        check_eq("t5_rdata", 32'(host_rdata), 32'd0);
        check_eq("t5_ready", 32'(host_ready), 32'd1);
        @(negedge clk); #1;
        check_eq("t5_rvalid_late", 32'(host_rvalid), 32'd0);
        last_rd = 16'h0;
        shadow[16'h0200] = 16'h7777;
        host_op('{wr: 1'b0, addr: 16'h0200, wdata: 16'h0000});
        wait_ready();

        // GUARD=3 / J0_SLOTS=4 build: period and pause length under a held request
        last_acc = -1; prun = 0; n_acc = 0;
        @(negedge clk);
        host_valid1 = 1'b1;
        #1;
        for (int c = 0; c < 40; c++) begin
            if (j0_pause1) prun++;
            else if (prun > 0) begin
                check_eq($sformatf("t6_pause_len%0d", n_acc), 32'(prun), 32'(G1 + 2));
                prun = 0;
            end
            if (host_ready1 && host_valid1) begin
                if (last_acc >= 0) check_eq($sformatf("t6_period%0d", n_acc), 32'(c - last_acc), 32'(G1 + S1 + 2));
                last_acc = c;
                n_acc++;
            end
            @(negedge clk); #1;
        end
        check_eq("t6_accepts", 32'(n_acc), 32'd5);
        host_valid1 = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("sb_drain", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
